// File: rtl/rtc_reg_master.sv
//==============================================================================
// Module   : rtc_reg_master
// Brief    : RTC register-bus initiator; arbitrates host commands and the
//            time/date snapshot engine, with a bounded ack timeout per access.
// Revision : 1.0
//==============================================================================
`default_nettype none

module rtc_reg_master #(
  parameter logic [4:0]  TIME_ADDR = 5'h00,
  parameter logic [4:0]  DATE_ADDR = 5'h01,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        rtc_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        snap_en,
  input  logic        snap_trig,
  output logic        snap_valid,
  output logic [31:0] snap_time,
  output logic [31:0] snap_date,
  output logic        snap_err,
  output logic        snap_drop,
  output logic        reg_cs,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  output logic        reg_wr,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_SNAP_T = 2'd2,
    ST_SNAP_D = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        snap_pend_q, snap_pend_d;
  logic        snap_drop_q, snap_drop_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        reg_cs_q, reg_cs_d;
  logic        reg_wr_q, reg_wr_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic [3:0]  reg_be_q, reg_be_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        snap_valid_q, snap_valid_d;
  logic [31:0] snap_time_q, snap_time_d;
  logic [31:0] snap_date_q, snap_date_d;
  logic        snap_err_q, snap_err_d;
  logic [31:0] tmp_time_q, tmp_time_d;
  logic        tmp_err_q, tmp_err_d;

  logic trig_en, ready_w, hit, tmo, acc_end, enter_t;

  assign trig_en   = snap_trig && snap_en;
  assign ready_w   = (state_q == ST_IDLE) && !snap_pend_q && !trig_en;
  // reg_ack only counts while the bus is selected; ack on the last cycle beats timeout
  assign hit       = reg_cs_q && reg_ack;
  assign tmo       = reg_cs_q && !reg_ack && (cnt_q == TO_LAST);
  assign acc_end   = hit || tmo;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    reg_cs_d     = reg_cs_q;
    reg_wr_d     = reg_wr_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_be_d     = reg_be_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    snap_valid_d = 1'b0;
    snap_time_d  = snap_time_q;
    snap_date_d  = snap_date_q;
    snap_err_d   = snap_err_q;
    tmp_time_d   = tmp_time_q;
    tmp_err_d    = tmp_err_q;
    enter_t      = 1'b0;

    if (reg_cs_q) begin
      cnt_d = acc_end ? 8'd0 : cnt_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (snap_pend_q) begin
          state_d     = ST_SNAP_T;
          enter_t     = 1'b1;
          reg_cs_d    = 1'b1;
          reg_wr_d    = 1'b0;
          reg_addr_d  = TIME_ADDR;
          reg_wdata_d = 32'd0;
          reg_be_d    = 4'hF;
        end else if (cmd_valid && ready_w) begin
          state_d     = ST_CMD;
          reg_cs_d    = 1'b1;
          reg_wr_d    = cmd_wr;
          reg_addr_d  = cmd_addr;
          reg_wdata_d = cmd_wdata;
          reg_be_d    = cmd_be;
        end
      end
      ST_CMD: begin
        if (acc_end) begin
          state_d     = ST_IDLE;
          reg_cs_d    = 1'b0;
          reg_wr_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (hit && !reg_wr_q) ? reg_rdata : 32'd0;
          rsp_err_d   = tmo;
        end
      end
      ST_SNAP_T: begin
        if (acc_end) begin
          state_d    = ST_SNAP_D;
          reg_cs_d   = 1'b0;
          reg_addr_d = DATE_ADDR;
          tmp_time_d = hit ? reg_rdata : 32'd0;
          tmp_err_d  = tmo;
        end
      end
      ST_SNAP_D: begin
        // first cycle here is the idle gap between the two reads
        if (!reg_cs_q) begin
          reg_cs_d = 1'b1;
        end else if (acc_end) begin
          state_d      = ST_IDLE;
          reg_cs_d     = 1'b0;
          snap_valid_d = 1'b1;
          snap_time_d  = tmp_time_q;
          snap_date_d  = hit ? reg_rdata : 32'd0;
          snap_err_d   = tmp_err_q || tmo;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    snap_pend_d = snap_en && (snap_trig || (snap_pend_q && !enter_t));
    snap_drop_d = trig_en && snap_pend_q;
  end

  always_ff @(posedge rtc_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      snap_pend_q  <= 1'b0;
      snap_drop_q  <= 1'b0;
      cnt_q        <= 8'd0;
      reg_cs_q     <= 1'b0;
      reg_wr_q     <= 1'b0;
      reg_addr_q   <= 5'd0;
      reg_wdata_q  <= 32'd0;
      reg_be_q     <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'd0;
      rsp_err_q    <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_time_q  <= 32'd0;
      snap_date_q  <= 32'd0;
      snap_err_q   <= 1'b0;
      tmp_time_q   <= 32'd0;
      tmp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_pend_q  <= snap_pend_d;
      snap_drop_q  <= snap_drop_d;
      cnt_q        <= cnt_d;
      reg_cs_q     <= reg_cs_d;
      reg_wr_q     <= reg_wr_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_be_q     <= reg_be_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      snap_valid_q <= snap_valid_d;
      snap_time_q  <= snap_time_d;
      snap_date_q  <= snap_date_d;
      snap_err_q   <= snap_err_d;
      tmp_time_q   <= tmp_time_d;
      tmp_err_q    <= tmp_err_d;
    end
  end

  assign cmd_ready  = ready_w;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign snap_valid = snap_valid_q;
  assign snap_time  = snap_time_q;
  assign snap_date  = snap_date_q;
  assign snap_err   = snap_err_q;
  assign snap_drop  = snap_drop_q;
  assign reg_cs     = reg_cs_q;
  assign reg_wr     = reg_wr_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign reg_be     = reg_be_q;

endmodule

`default_nettype wire

// File: tb/tb_rtc_reg_master.sv
//==============================================================================
// Module   : tb_rtc_reg_master
// Brief    : Scoreboard bench for rtc_reg_master with an RTC register responder.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_rtc_reg_master;

  localparam int TO = 64;

  logic        rtc_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [4:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_be = '0;
  logic        snap_en = 1'b1, snap_trig = 1'b0;
  logic        reg_ack = 1'b0;
  logic [31:0] reg_rdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err, snap_valid, snap_err, snap_drop;
  logic [31:0] rsp_rdata, snap_time, snap_date, reg_wdata;
  logic        reg_cs, reg_wr;
  logic [4:0]  reg_addr;
  logic [3:0]  reg_be;

  rtc_reg_master #(.TIME_ADDR(5'h00), .DATE_ADDR(5'h01), .TIMEOUT(TO)) dut (
    .rtc_clk(rtc_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .snap_en(snap_en), .snap_trig(snap_trig), .snap_valid(snap_valid),
    .snap_time(snap_time), .snap_date(snap_date), .snap_err(snap_err),
    .snap_drop(snap_drop), .reg_cs(reg_cs), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_wr(reg_wr),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack)
  );

  always #5 rtc_clk = ~rtc_clk;

  typedef struct { logic [4:0] addr; logic wr; logic [31:0] wdata; logic [3:0] be; int len; int gap; } bus_t;
  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { logic [31:0] t; logic [31:0] d; logic err; } snp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  snp_t snp_q[$];

  int total = 0, bad = 0;
  int rsp_cnt = 0, snp_cnt = 0, drop_cnt = 0;
  int ack_delay = 1;   // ack on this cs-high cycle; 0 = never
  bit spur = 0;        // random acks while cs is low
  logic [31:0] rtc_mem [32];
  logic [31:0] ref_mem [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // RTC register file responder
  int rc = 0;
  always @(negedge rtc_clk) begin
    if (reg_cs) begin
      rc++;
      reg_ack = (ack_delay != 0) && (rc == ack_delay);
      reg_rdata = $urandom;
      if (reg_ack && !reg_wr) reg_rdata = rtc_mem[reg_addr];
      if (reg_ack && reg_wr)
        for (int b = 0; b < 4; b++)
          if (reg_be[b]) rtc_mem[reg_addr][8*b +: 8] = reg_wdata[8*b +: 8];
    end else begin
      rc = 0;
      reg_ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      reg_rdata = $urandom;
    end
  end

  // monitor: bus accesses, responses, snapshots
  int cyc = 0, run_len = 0, fall_cyc = -10, rise_cyc = 0;
  bus_t cur, e;
  rsp_t er;
  snp_t es;
  always @(negedge rtc_clk) begin
    cyc++;
    if (rst) begin
      run_len = 0;
    end else begin
      if (reg_cs) begin
        if (run_len == 0) begin
          rise_cyc = cyc;
          cur.addr = reg_addr; cur.wr = reg_wr; cur.wdata = reg_wdata; cur.be = reg_be;
          if (bus_q.size() > 0 && bus_q[0].gap == 1) chk("snap_gap", 32'(rise_cyc - fall_cyc), 32'd1);
        end else begin
          chk("bus_stable", {reg_addr, reg_wr, reg_be, 22'd0} ^ reg_wdata,
              {cur.addr, cur.wr, cur.be, 22'd0} ^ cur.wdata);
        end
        run_len++;
      end else if (run_len != 0) begin
        fall_cyc = cyc;
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_unexpected: addr %h len %0d, none expected", cur.addr, run_len);
        end else begin
          e = bus_q.pop_front();
          chk("bus_addr", 32'(cur.addr), 32'(e.addr));
          chk("bus_wr", 32'(cur.wr), 32'(e.wr));
          chk("bus_wdata", cur.wdata, e.wdata);
          chk("bus_be", 32'(cur.be), 32'(e.be));
          chk("bus_len", 32'(run_len), 32'(e.len));
        end
        run_len = 0;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: rdata %h err %b, none expected", rsp_rdata, rsp_err);
        end else begin
          er = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, er.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(er.err));
          chk("rsp_latency", 32'(cyc), 32'(fall_cyc));
        end
      end
      if (snap_valid) begin
        snp_cnt++;
        if (snp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL snap_unexpected: time %h date %h, none expected", snap_time, snap_date);
        end else begin
          es = snp_q.pop_front();
          chk("snap_time", snap_time, es.t);
          chk("snap_date", snap_date, es.d);
          chk("snap_err", 32'(snap_err), 32'(es.err));
          chk("snap_latency", 32'(cyc), 32'(fall_cyc));
        end
      end
      if (snap_drop) drop_cnt++;
    end
  end

  function automatic bit acked(input int d);
    return (d >= 1) && (d <= TO);
  endfunction

  function automatic int cs_len(input int d);
    return acked(d) ? d : TO;
  endfunction

  task automatic push_snap(input int d);
    snp_t s;
    bus_q.push_back('{5'h00, 1'b0, 32'd0, 4'hF, cs_len(d), 0});
    bus_q.push_back('{5'h01, 1'b0, 32'd0, 4'hF, cs_len(d), 1});
    s.t = acked(d) ? ref_mem[0] : 32'd0;
    s.d = acked(d) ? ref_mem[1] : 32'd0;
    s.err = !acked(d);
    snp_q.push_back(s);
  endtask

  task automatic wait_snaps(input int n);
    int target;
    target = snp_cnt + n;
    for (int i = 0; i < 1000 && snp_cnt < target; i++) @(negedge rtc_clk);
    if (snp_cnt < target) begin
      total++; bad++;
      $display("FAIL snap_wait: got %0d snapshots want %0d", snp_cnt, target);
    end
  endtask

  task automatic issue_cmd(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input int d, input bit with_trig);
    rsp_t r;
    bit acc;
    int n0;
    ack_delay = d;
    bus_q.push_back('{a, wr, wd, be, cs_len(d), 0});
    r.rdata = (acked(d) && !wr) ? ref_mem[a] : 32'd0;
    r.err = !acked(d);
    rsp_q.push_back(r);
    if (acked(d) && wr)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
    n0 = rsp_cnt;
    acc = 0;
    @(negedge rtc_clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = wd; cmd_be = be;
    if (with_trig) snap_trig = 1'b1;
    #1;
    if (with_trig) chk("trig_blocks_ready", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 400 && !acc; i++) begin
      if (i > 0) begin
        @(negedge rtc_clk);
        snap_trig = 1'b0;
        #1;
      end
      if (cmd_ready) begin
        acc = 1;
        @(posedge rtc_clk);
      end
    end
    @(negedge rtc_clk);
    cmd_valid = 1'b0; snap_trig = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL cmd_accept: cmd_ready never seen, want accept");
      return;
    end
    for (int i = 0; i < 400 && rsp_cnt == n0; i++) @(negedge rtc_clk);
    if (rsp_cnt == n0) begin
      total++; bad++;
      $display("FAIL rsp_wait: got no response want one");
    end
  endtask

  task automatic pulse_trig();
    @(negedge rtc_clk); snap_trig = 1'b1;
    @(negedge rtc_clk); snap_trig = 1'b0;
  endtask

  initial begin
    bit found;
    int n0;
    int r, d;
    for (int i = 0; i < 32; i++) begin
      rtc_mem[i] = $urandom;
      ref_mem[i] = rtc_mem[i];
    end
    repeat (3) @(negedge rtc_clk);
    chk("rst_reg_cs", 32'(reg_cs), 32'd0);
    chk("rst_reg_wr", 32'(reg_wr), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_snap_valid", 32'(snap_valid), 32'd0);
    chk("rst_snap_time", snap_time, 32'd0);
    chk("rst_snap_drop", 32'(snap_drop), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge rtc_clk);

    issue_cmd(1'b1, 5'h05, 32'h12345678, 4'hF, 2, 0);
    rtc_mem[0] = 32'h00235959; ref_mem[0] = 32'h00235959;
    issue_cmd(1'b0, 5'h00, 32'h0, 4'hF, 1, 0);
    issue_cmd(1'b0, 5'h05, 32'h0, 4'hF, 0, 0);
    issue_cmd(1'b0, 5'h05, 32'h0, 4'hF, TO, 0);
    issue_cmd(1'b1, 5'h07, 32'hA5A5A5A5, 4'h5, TO + 1, 0);

    rtc_mem[0] = 32'h00120000; ref_mem[0] = 32'h00120000;
    rtc_mem[1] = 32'h20221118; ref_mem[1] = 32'h20221118;
    ack_delay = 2;
    push_snap(2);
    pulse_trig();
    wait_snaps(1);

    ack_delay = 0;
    push_snap(0);
    pulse_trig();
    wait_snaps(1);

    // snapshot and host command requested together
    push_snap(2);
    issue_cmd(1'b0, 5'h01, 32'h0, 4'hF, 2, 1);

    // trigger during SNAP_D, then another while that one is still pending
    ack_delay = 4;
    push_snap(4);
    push_snap(4);
    pulse_trig();
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge rtc_clk);
      if (reg_cs && reg_addr == 5'h01) found = 1;
    end
    chk("found_snap_d", 32'(found), 32'd1);
    snap_trig = 1'b1;
    @(negedge rtc_clk); snap_trig = 1'b0;
    @(negedge rtc_clk); snap_trig = 1'b1;
    @(negedge rtc_clk); snap_trig = 1'b0;
    wait_snaps(2);
    repeat (5) @(negedge rtc_clk);
    chk("snap_drop_count", 32'(drop_cnt), 32'd1);

    spur = 1;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      d = (r <= 6) ? r + 1 : (r == 7) ? 0 : (r == 8) ? TO : TO + 1;
      issue_cmd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                4'($urandom_range(0, 15)), d, 0);
    end
    spur = 0;

    // reset in the middle of a host access
    ack_delay = 0;
    @(negedge rtc_clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 5'h03; cmd_be = 4'hF;
    @(negedge rtc_clk); cmd_valid = 1'b0;
    repeat (4) @(negedge rtc_clk);
    chk("mid_cmd_cs_high", 32'(reg_cs), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_cs", 32'(reg_cs), 32'd0);
    chk("rst_async_rsp", 32'(rsp_valid), 32'd0);
    @(negedge rtc_clk); rst = 1'b0;
    n0 = rsp_cnt;
    repeat (TO + 20) @(negedge rtc_clk);
    chk("no_rsp_after_rst", 32'(rsp_cnt), 32'(n0));
    #1;
    chk("idle_after_rst", 32'(cmd_ready), 32'd1);

    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    chk("snp_q_empty", 32'(snp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
